tri_stream_receiver: RTL



---
 rtl/tri_pkg.sv | 33 +++
 rtl/tri_fifo.sv | 58 +++++
 rtl/tri_stream_receiver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tri_pkg.sv
// Shared types for the triangle stream receiver: the buffered record layout
// and the three-vertex min/max helper used to build the bounding box.
package tri_pkg;

  localparam int COORD_W = 16;
  localparam int COLOR_W = 16;

  typedef struct packed {
    logic [3*COORD_W-1:0] x;
    logic [3*COORD_W-1:0] y;
    logic [3*COORD_W-1:0] z;
    logic [COLOR_W-1:0]   color;
    logic [COORD_W-1:0]   xmin;
    logic [COORD_W-1:0]   xmax;
    logic [COORD_W-1:0]   ymin;
    logic [COORD_W-1:0]   ymax;
    logic                 last;
  } tri_rec_t;

  // Returns {max, min} over the three packed vertex coordinates {v2,v1,v0}.
  function automatic logic [2*COORD_W-1:0] min_max3(input logic [3*COORD_W-1:0] v);
    logic [COORD_W-1:0] a, b, c, mn, mx;
    a  = v[COORD_W-1:0];
    b  = v[2*COORD_W-1:COORD_W];
    c  = v[3*COORD_W-1:2*COORD_W];
    mn = (a < b) ? a : b;
    mn = (c < mn) ? c : mn;
    mx = (a > b) ? a : b;
    mx = (c > mx) ? c : mx;
    return {mx, mn};
  endfunction

endpackage

// File: rtl/tri_fifo.sv
// First-word-fall-through FIFO of triangle records; the head is visible
// combinationally whenever the FIFO is not empty.
module tri_fifo
  import tri_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          i_push,
  input  tri_rec_t      i_rec,
  input  logic          i_pop,
  output tri_rec_t      o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  tri_rec_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: storage is deliberately not reset; emptiness is tracked by the
  // pointers and level alone, and the head is masked while empty.
  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_rec;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/tri_stream_receiver.sv
// Receives generator triangles, registers them with their bounding box,
// buffers them for the rasterizer and keeps per-frame counts and overflow.
module tri_stream_receiver
  import tri_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 12,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [3*COORD_W-1:0] triangle_x,
  input  logic [3*COORD_W-1:0] triangle_y,
  input  logic [3*COORD_W-1:0] triangle_z,
  input  logic [COLOR_W-1:0]   color,
  input  logic                 last_in,
  input  logic                 tri_ready_in,
  output logic                 tri_valid_out,
  output logic [3*COORD_W-1:0] tri_x_out,
  output logic [3*COORD_W-1:0] tri_y_out,
  output logic [3*COORD_W-1:0] tri_z_out,
  output logic [COLOR_W-1:0]   tri_color_out,
  output logic [4*COORD_W-1:0] bbox_out,
  output logic                 tri_last_out,
  output logic                 frame_done_out,
  output logic [CNT_W-1:0]     frame_count_out,
  output logic                 overflow_out,
  output logic [LW-1:0]        fifo_level_out
);

  tri_rec_t              w_rec;
  tri_rec_t              w_head;
  logic [2*COORD_W-1:0]  w_x_mm;
  logic [2*COORD_W-1:0]  w_y_mm;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [CNT_W-1:0]      w_cnt_inc;

  tri_rec_t              r_s1;
  logic                  r_s1_valid;
  logic                  r_overflow;
  logic                  r_frame_done;
  logic [CNT_W-1:0]      r_frame_cnt;
  logic [CNT_W-1:0]      r_frame_count;

  // NOTE: every field of w_rec is assigned on every pass, so no latch forms.
  always_comb begin
    w_x_mm     = min_max3(triangle_x);
    w_y_mm     = min_max3(triangle_y);
    w_rec.x     = triangle_x;
    w_rec.y     = triangle_y;
    w_rec.z     = triangle_z;
    w_rec.color = color;
    w_rec.xmin  = w_x_mm[COORD_W-1:0];
    w_rec.xmax  = w_x_mm[2*COORD_W-1:COORD_W];
    w_rec.ymin  = w_y_mm[COORD_W-1:0];
    w_rec.ymax  = w_y_mm[2*COORD_W-1:COORD_W];
    w_rec.last  = last_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      r_s1_valid <= valid_in;
      if (valid_in) r_s1 <= w_rec;
    end
  end

  assign w_pop     = ~w_empty & tri_ready_in;
  assign w_push    = r_s1_valid & (~w_full | w_pop);
  assign w_drop    = r_s1_valid & ~w_push;
  assign w_cnt_inc = (w_push && r_frame_cnt != '1) ? r_frame_cnt + CNT_W'(1) : r_frame_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_overflow    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_cnt   <= '0;
      r_frame_count <= '0;
    end else begin
      r_overflow   <= r_overflow | w_drop;
      r_frame_done <= 1'b0;
      if (r_s1_valid && r_s1.last) begin
        r_frame_done  <= 1'b1;
        r_frame_count <= w_cnt_inc;
        r_frame_cnt   <= '0;
      end else begin
        r_frame_cnt   <= w_cnt_inc;
      end
    end
  end

  tri_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_push),
    .i_rec   (r_s1),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level_out)
  );

  assign tri_valid_out   = ~w_empty;
  assign tri_x_out       = w_head.x;
  assign tri_y_out       = w_head.y;
  assign tri_z_out       = w_head.z;
  assign tri_color_out   = w_head.color;
  assign bbox_out        = {w_head.xmax, w_head.xmin, w_head.ymax, w_head.ymin};
  assign tri_last_out    = w_head.last;
  assign frame_done_out  = r_frame_done;
  assign frame_count_out = r_frame_count;
  assign overflow_out    = r_overflow;

endmodule
